// File: rtl/aes_enc_ctrl.sv
// Iterative AES-128 encryption core: one round per clock, with an on-the-fly
// key schedule, a valid/ready input handshake and a held ciphertext output.
module aes_enc_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt_in,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ct_out,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  localparam logic [3:0] LAST_RND = 4'(NR);

  fsm_t         fsm, fsm_nxt;
  logic [3:0]   rnd;
  logic [127:0] state_q;
  logic [127:0] rk_q;
  logic [127:0] rk_next;
  logic [127:0] round_out;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    // NOTE: blocking '=' is correct inside functions and always_comb; only
    // clocked state uses '<=' so every flop updates from pre-edge values.
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box computed algebraically: inverse as a^254 (0 maps to 0), then affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
           {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Byte n sits at bits 127-8n; column c holds bytes 4c..4c+3, row r = n%4.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  // One full cipher round from the registered state; last round skips MixColumns.
  always_comb begin
    logic [127:0] sr;
    rk_next   = expand(rk_q, rcon(rnd));
    sr        = sub_shift(state_q);
    round_out = ((rnd == LAST_RND) ? sr : mix_columns(sr)) ^ rk_next;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm <= IDLE;
    else     fsm <= fsm_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    fsm_nxt   = fsm;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    ct_out    = '0;
    case (fsm)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) fsm_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (rnd == LAST_RND) fsm_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        ct_out    = state_q;
        if (out_ready) fsm_nxt = IDLE;
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  // Datapath registers: load on accept, advance one round per RUN cycle, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the datapath registers are plain flops (not a memory array), so they
    // are cleared on reset to keep ct_out and the round state deterministic.
    if (rst) begin
      rnd     <= 4'd0;
      state_q <= '0;
      rk_q    <= '0;
    end else begin
      case (fsm)
        IDLE: if (in_valid) begin
          state_q <= pt_in ^ key_in;
          rk_q    <= key_in;
          rnd     <= 4'd1;
        end
        RUN: begin
          state_q <= round_out;
          rk_q    <= rk_next;
          rnd     <= rnd + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/aes_enc_ctrl.md
AES_ENC_CTRL -- requirements
Module: aes_enc_ctrl

Interface
REQ-001 SHALL have parameter NR, default 10, number of cipher rounds; only 10 (AES-128) is supported.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous, active-high; the block has one clock and this one reset.
REQ-004 in_valid  input  1  plaintext/key pair offered.
REQ-005 in_ready  output  1  block can accept a pair.
REQ-006 pt_in  input  128  plaintext; bits 127:120 are byte 0 (FIPS-197 order).
REQ-007 key_in  input  128  cipher key, same byte order.
REQ-008 out_valid  output  1  ciphertext available.
REQ-009 out_ready  input  1  consumer accepts ciphertext.
REQ-010 ct_out  output  128  ciphertext, same byte order.
REQ-011 busy  output  1  high in RUN or DONE.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE, plus a 4-bit round counter rnd, a 128-bit state register and a 128-bit round-key register.
REQ-013 IDLE: in_ready=1; when in_valid=1, the edge SHALL load state=pt_in^key_in and rk=key_in, set rnd=1, and go to RUN.
REQ-014 RUN: in_ready=0; each edge SHALL perform one round: rk_next=expand(rk,rcon[rnd]); state=SubBytes->ShiftRows->MixColumns->AddRoundKey(rk_next); MixColumns SHALL be skipped when rnd=NR.
REQ-015 Key expansion: w0'=w0^SubWord(RotWord(w3))^{rcon,24'h0}; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2' (w0=rk[127:96]).
REQ-016 rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1b,36.
REQ-017 RUN: rnd SHALL increment each edge; on the edge where rnd=NR the FSM SHALL go to DONE.
REQ-018 DONE: out_valid=1 and ct_out=state; ct_out SHALL stay stable while out_valid=1 and out_ready=0.
REQ-019 DONE with out_ready=1: the edge SHALL go to IDLE; no new pair SHALL be accepted on that same edge.
REQ-020 Latency: out_valid SHALL first be high in the cycle after the 11th rising edge, counting the accepting edge as edge 1.
REQ-021 Throughput: at most one block per 12 cycles, with out_ready held high.
REQ-022 pt_in and key_in SHALL be sampled only on the accepting edge; later changes SHALL have no effect on the result.
REQ-023 in_valid SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE.
REQ-024 ct_out SHALL read 0 whenever out_valid=0.
REQ-025 busy SHALL be 1 exactly when the state is RUN or DONE.

Reset
REQ-026 While rst=1 the block SHALL immediately enter IDLE, with in_ready=1, out_valid=0, busy=0, ct_out=0, rnd=0, and state and rk registers=0.
REQ-027 Reset asserted during RUN or DONE SHALL abandon the operation; no out_valid pulse SHALL follow the reset release.
REQ-028 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-029 FIPS-197 C.1 vector: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, out_ready=1 -> ct_out 69c4e0d86a7b0430d8cdb78070b4c55a with out_valid on the cycle given in REQ-020 and high for exactly 1 cycle.
REQ-030 FIPS-197 App. B vector: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct_out 3925841d02dc09fbdc118597196a0b32.
REQ-031 Backpressure: hold out_ready=0 for 5 cycles after out_valid rises -> ct_out stable, in_ready=0 throughout, and a return to IDLE one edge after out_ready=1.
REQ-032 Input churn: change pt_in/key_in every cycle during RUN, and hold in_valid=1 during RUN and DONE -> result still matches REQ-029; the second pair is accepted only in IDLE.
REQ-033 Mid-run reset: pulse rst at rnd=5 -> immediately in_ready=1, out_valid=0, busy=0; then re-run REQ-030 -> correct ciphertext.
REQ-034 Back-to-back: issue the REQ-029 and REQ-030 pairs with in_valid and out_ready both held at 1 -> both ciphertexts are correct and in order, with accepts 12 cycles apart.
